// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame constants, state encoding and parity helper.
package uart_pkg;
  localparam int DATA_BITS            = 8;
  localparam int FRAME_BITS           = 11;
  localparam int DEFAULT_CLKS_PER_BIT = 16;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  output logic bit_end
);
  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  logic [W-1:0] cnt_q, cnt_d;
  assign bit_end = cnt_q == W'(CLKS_PER_BIT - 1);
  always_comb cnt_d = (restart || bit_end) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: 8E1 UART transmitter with a valid/ready byte input and registered line output.
// Define UART_TX_TWO_STOP_EN to send two stop bits (12-bit frame).
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);
`ifdef UART_TX_TWO_STOP_EN
  localparam int STOP_BITS = 2;
`else
  localparam int STOP_BITS = 1;
`endif
  uart_state_e          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]           idx_q, idx_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 bit_end;
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (state_q == IDLE),
    .bit_end (bit_end)
  );
  assign tx_ready = state_q == IDLE;
  assign tx_busy  = state_q != IDLE;
  assign tx       = tx_q;
  assign tx_done  = state_q == STOP && bit_end && idx_q == 3'(STOP_BITS - 1);
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;
    unique case (state_q)
      IDLE: if (tx_valid) begin
        shift_d = tx_data;
        par_d   = even_parity(tx_data);
        idx_d   = '0;
        state_d = START;
      end
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        idx_d   = idx_q + 1'b1;
        state_d = idx_q == 3'(DATA_BITS - 1) ? PARITY : DATA;
      end
      PARITY: if (bit_end) begin
        idx_d   = '0;
        state_d = STOP;
      end
      STOP: if (bit_end) begin
        idx_d   = tx_done ? 3'd0 : idx_q + 1'b1;
        state_d = tx_done ? IDLE : STOP;
      end
      default: state_d = IDLE;
    endcase
    // Line value is computed from the next state so tx leaves a flop aligned with the state.
    tx_d = state_d == START  ? 1'b0 :
           state_d == DATA   ? shift_d[0] :
           state_d == PARITY ? par_d : 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboarded random/directed checks of uart_tx frames, timing and reset.
module tb_uart_tx;
  localparam int CPB = 16;
`ifdef UART_TX_TWO_STOP_EN
  localparam int STOPS = 2;
`else
  localparam int STOPS = 1;
`endif
  localparam int L = CPB * (10 + STOPS);
  typedef struct {
    logic [7:0] b;
    int         c;
  } exp_t;
  logic       clk = 0, rst_n = 1, tx_valid = 0;
  logic [7:0] tx_data = 0;
  logic       tx, tx_ready, tx_busy, tx_done;
  exp_t       q[$];
  exp_t       cur;
  bit         active = 0;
  logic [11:0] bits;
  int         cyc = 0, hs_cnt = 0, tests = 0, fails = 0, t;
  uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%b exp=%b", n, cyc, a, e);
    end
  endtask
  // Expected line bits in transmission order: start, data LSB first, even parity, stop(s).
  function automatic logic [11:0] frame_of(input logic [7:0] b);
    return {2'b11, 1'($countones(b) % 2), b, 1'b0};
  endfunction
  always @(posedge clk) begin
    if (rst_n && tx_valid && tx_ready) begin
      q.push_back('{b: tx_data, c: cyc});
      hs_cnt++;
    end
    cyc++;
  end
  always @(negedge clk) begin
    if (!rst_n) begin
      active = 0;
      q.delete();
      chk("reset", {tx, tx_done, tx_busy, tx_ready}, 4'b1001);
    end else begin
      if (!active && q.size() > 0 && cyc == q[0].c + 1) begin
        cur    = q.pop_front();
        active = 1;
        bits   = frame_of(cur.b);
      end
      if (active) begin
        t = cyc - cur.c;
        chk($sformatf("frame_%02h_t%0d", cur.b, t), {tx, tx_done, tx_busy, tx_ready},
            {bits[(t-1)/CPB], t == L, 2'b10});
        if (t == L) active = 0;
      end else
        chk("idle", {tx, tx_done, tx_busy, tx_ready}, 4'b1001);
    end
  end
  task automatic step(input int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask
  task automatic send(input logic [7:0] b);
    int n0 = hs_cnt;
    int k  = 0;
    tx_valid = 1;
    tx_data  = b;
    while (hs_cnt == n0 && k < 1000) begin step(1); k++; end
    if (hs_cnt == n0) chk("hs_timeout", 0, 1);
  endtask
  task automatic drain();
    int k = 0;
    while ((q.size() > 0 || active) && k < 1000) begin step(1); k++; end
    if (q.size() > 0 || active) chk("drain_timeout", 0, 1);
    step(2);
  endtask
  initial begin
    #2 rst_n = 0;
    #1 chk("rst_async", {tx, tx_done, tx_busy, tx_ready}, 4'b1001);
    step(3);
    rst_n = 1;
    step(5);
    send(8'hA5); tx_valid = 0; drain();
    send(8'h07); tx_valid = 0; drain();
    send(8'h55); send(8'hAA); tx_valid = 0; drain();
    send(8'h3C); step(49);
    tx_data = 8'hFF;
    send(8'hFF); tx_valid = 0; drain();
    send(8'h12); tx_valid = 0; step(79);
    rst_n = 0;
    #1 chk("rst_mid", {tx, tx_done, tx_busy, tx_ready}, 4'b1001);
    step(3);
    rst_n = 1;
    step(20);
    send(8'h81); tx_valid = 0; drain();
    send(8'h00); tx_valid = 0; drain();
    repeat (20) begin
      send(8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        tx_valid = 0;
        step($urandom_range(0, 200));
      end
    end
    tx_valid = 0;
    drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
